// File: rtl/nbody_pair_scheduler.sv
// Walks every ordered particle pair (i,j), j!=i, of a full input buffer and streams
// each pair's positions/mass to the force pipeline, then clears the buffer for the next frame.
module nbody_pair_scheduler #(
  parameter int unsigned N        = 4,
  parameter int unsigned IDX_BITS = $clog2(N)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                buf_full_i,
  output logic                buf_clear_o,
  output logic [IDX_BITS-1:0] buf_rd_idx_o,
  output logic [1:0]          buf_rd_sel_o,
  input  logic [15:0]         buf_data_i,
  output logic                pair_valid_o,
  input  logic                pair_ready_i,
  output logic [IDX_BITS-1:0] pair_i_o,
  output logic [IDX_BITS-1:0] pair_j_o,
  output logic [15:0]         pair_xi_o,
  output logic [15:0]         pair_yi_o,
  output logic [15:0]         pair_xj_o,
  output logic [15:0]         pair_yj_o,
  output logic [15:0]         pair_mj_o,
  output logic                pair_last_j_o,
  output logic                pair_last_o,
  output logic                busy_o,
  output logic                frame_done_o
);

  localparam int unsigned CW = IDX_BITS + 1;
  localparam int unsigned DW = 16;
  localparam logic [IDX_BITS-1:0] LAST_IDX   = IDX_BITS'(N - 1);
  localparam logic [IDX_BITS-1:0] PENULT_IDX = IDX_BITS'(N - 2);
  localparam logic [CW-1:0]       LAST_IDX_W = CW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_I,
    S_LOAD_J,
    S_EMIT,
    S_CLEAR
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          sub_q, sub_d;
  logic [IDX_BITS-1:0] i_q, i_d;
  logic [IDX_BITS-1:0] j_q, j_d;
  logic [CW-1:0]       j_inc, j_nxt;

  logic                clear_q, clear_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;
  logic                last_j_q, last_j_d;
  logic                last_q, last_d;
  logic [IDX_BITS-1:0] rd_idx_q, rd_idx_d;
  logic [1:0]          rd_sel_q, rd_sel_d;
  logic [DW-1:0]       xi_q, xi_d;
  logic [DW-1:0]       yi_q, yi_d;
  logic [DW-1:0]       xj_q, xj_d;
  logic [DW-1:0]       yj_q, yj_d;
  logic [DW-1:0]       mj_q, mj_d;

  // FSM state and pair-walk counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      sub_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      sub_q   <= sub_d;
      i_q     <= i_d;
      j_q     <= j_d;
    end
  end

  // Next state; j_inc is one bit wider so the end-of-row test cannot wrap
  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    i_d     = i_q;
    j_d     = j_q;
    j_inc   = {1'b0, j_q} + CW'(1);
    j_nxt   = (j_inc == {1'b0, i_q}) ? j_inc + CW'(1) : j_inc;
    unique case (state_q)
      S_IDLE: begin
        if (en_i && buf_full_i) begin
          state_d = S_LOAD_I;
          sub_d   = '0;
          i_d     = '0;
          j_d     = IDX_BITS'(1);
        end
      end
      S_LOAD_I: begin
        if (sub_q == 2'd2) begin
          state_d = S_LOAD_J;
          sub_d   = '0;
        end else begin
          sub_d = sub_q + 2'd1;
        end
      end
      S_LOAD_J: begin
        if (sub_q == 2'd2) begin
          state_d = S_EMIT;
          sub_d   = '0;
        end else begin
          sub_d = sub_q + 2'd1;
        end
      end
      S_EMIT: begin
        if (pair_ready_i) begin
          if (j_nxt <= LAST_IDX_W) begin
            state_d = S_LOAD_J;
            j_d     = j_nxt[IDX_BITS-1:0];
          end else if (i_q != LAST_IDX) begin
            state_d = S_LOAD_I;
            i_d     = i_q + IDX_BITS'(1);
            j_d     = '0;
          end else begin
            state_d = S_CLEAR;
          end
        end
      end
      S_CLEAR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output next values; read port follows the upcoming state so data lines up with the load cycle
  always_comb begin
    rd_idx_d = '0;
    rd_sel_d = '0;
    valid_d  = 1'b0;
    last_j_d = 1'b0;
    last_d   = 1'b0;
    busy_d   = (state_d != S_IDLE);
    clear_d  = (state_d == S_CLEAR);
    done_d   = (state_d == S_CLEAR);
    xi_d     = xi_q;
    yi_d     = yi_q;
    xj_d     = xj_q;
    yj_d     = yj_q;
    mj_d     = mj_q;

    if (state_d == S_LOAD_I) begin
      rd_idx_d = i_d;
      rd_sel_d = sub_d;
    end else if (state_d == S_LOAD_J) begin
      rd_idx_d = j_d;
      rd_sel_d = sub_d;
    end

    if (state_d == S_EMIT) begin
      valid_d  = 1'b1;
      last_d   = (i_d == LAST_IDX) && (j_d == PENULT_IDX);
      last_j_d = (j_d == LAST_IDX) || last_d;
    end

    // Mass of i is read but not needed; that slot only keeps the 3-cycle cadence
    if (state_q == S_LOAD_I) begin
      if (sub_q == 2'd0) xi_d = buf_data_i;
      if (sub_q == 2'd1) yi_d = buf_data_i;
    end
    if (state_q == S_LOAD_J) begin
      if (sub_q == 2'd0) xj_d = buf_data_i;
      if (sub_q == 2'd1) yj_d = buf_data_i;
      if (sub_q == 2'd2) mj_d = buf_data_i;
    end
  end

  // Registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clear_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      last_j_q <= 1'b0;
      last_q   <= 1'b0;
      rd_idx_q <= '0;
      rd_sel_q <= '0;
      xi_q     <= '0;
      yi_q     <= '0;
      xj_q     <= '0;
      yj_q     <= '0;
      mj_q     <= '0;
    end else begin
      clear_q  <= clear_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      last_j_q <= last_j_d;
      last_q   <= last_d;
      rd_idx_q <= rd_idx_d;
      rd_sel_q <= rd_sel_d;
      xi_q     <= xi_d;
      yi_q     <= yi_d;
      xj_q     <= xj_d;
      yj_q     <= yj_d;
      mj_q     <= mj_d;
    end
  end

  assign buf_clear_o   = clear_q;
  assign frame_done_o  = done_q;
  assign busy_o        = busy_q;
  assign pair_valid_o  = valid_q;
  assign pair_last_j_o = last_j_q;
  assign pair_last_o   = last_q;
  assign buf_rd_idx_o  = rd_idx_q;
  assign buf_rd_sel_o  = rd_sel_q;
  assign pair_i_o      = i_q;
  assign pair_j_o      = j_q;
  assign pair_xi_o     = xi_q;
  assign pair_yi_o     = yi_q;
  assign pair_xj_o     = xj_q;
  assign pair_yj_o     = yj_q;
  assign pair_mj_o     = mj_q;

endmodule

// File: tb/tb_nbody_pair_scheduler.sv
// Directed bench for nbody_pair_scheduler: N=4 frame order/data, backpressure,
// idle gating, mid-frame async reset and read-port cadence.
module tb_nbody_pair_scheduler;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        full;
  logic        buf_clear;
  logic [1:0]  rd_idx;
  logic [1:0]  rd_sel;
  logic [15:0] buf_data;
  logic        valid;
  logic        ready;
  logic [1:0]  pi;
  logic [1:0]  pj;
  logic [15:0] xi, yi, xj, yj, mj;
  logic        last_j;
  logic        p_last;
  logic        busy;
  logic        frame_done;

  logic [15:0] mem [4][4];

  int vectors     = 0;
  int miscompares = 0;

  int exp_i [12] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3};
  int exp_j [12] = '{1, 2, 3, 0, 2, 3, 0, 1, 3, 0, 1, 2};

  nbody_pair_scheduler #(.N(4), .IDX_BITS(2)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .en_i          (en),
    .buf_full_i    (full),
    .buf_clear_o   (buf_clear),
    .buf_rd_idx_o  (rd_idx),
    .buf_rd_sel_o  (rd_sel),
    .buf_data_i    (buf_data),
    .pair_valid_o  (valid),
    .pair_ready_i  (ready),
    .pair_i_o      (pi),
    .pair_j_o      (pj),
    .pair_xi_o     (xi),
    .pair_yi_o     (yi),
    .pair_xj_o     (xj),
    .pair_yj_o     (yj),
    .pair_mj_o     (mj),
    .pair_last_j_o (last_j),
    .pair_last_o   (p_last),
    .busy_o        (busy),
    .frame_done_o  (frame_done)
  );

  assign buf_data = mem[rd_idx][rd_sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rec_vec();
    return 128'({pi, pj, xi, yi, xj, yj, mj, last_j, p_last});
  endfunction

  function automatic logic [127:0] exp_rec(input int r);
    int  a = exp_i[r];
    int  b = exp_j[r];
    logic lj = (r == 2) || (r == 5) || (r == 8) || (r == 11);
    logic l  = (r == 11);
    return 128'({2'(a), 2'(b), mem[a][0], mem[a][1], mem[b][0], mem[b][1], mem[b][2], lj, l});
  endfunction

  function automatic logic [127:0] all_out();
    return 128'({buf_clear, rd_idx, rd_sel, valid, pi, pj, xi, yi, xj, yj, mj,
                 last_j, p_last, busy, frame_done});
  endfunction

  // One frame; stall_idx stalls that record 5 cycles, abort_idx resets during its EMIT
  task automatic run_frame(input int stall_idx, input int abort_idx, input int exp_len,
                           input bit trace);
    int rec = 0, stall_cnt = 0, busy_cnt = 0, clr_cnt = 0, clr_edge = 0, sel3 = 0, m = 0;
    logic [127:0] snap = '0;
    logic [127:0] cur;
    bit done = 1'b0, aborted = 1'b0;
    en = 1'b1; full = 1'b1; ready = 1'b1;
    while (!done && m < 300) begin
      @(posedge clk); #1; m++;
      if (m == 1) begin
        chk("start_busy", 128'(busy), 128'(1));
        en = 1'b0; full = 1'b0;
      end
      cur = rec_vec();
      if (busy) busy_cnt++;
      if (buf_clear || frame_done) begin
        clr_cnt++; clr_edge = m;
        chk("done_with_clear", 128'(frame_done), 128'(buf_clear));
      end
      if (rd_sel == 2'd3) sel3++;
      if (trace && m >= 12 && m <= 14) begin
        chk("rd_idx_j3", 128'(rd_idx), 128'(3));
        chk("rd_sel_j3", 128'(rd_sel), 128'(m - 12));
      end
      if (rec == stall_idx && stall_cnt > 0) begin
        chk("stall_valid", 128'(valid), 128'(1));
        chk("stall_hold", cur, snap);
        chk("stall_rd", 128'({rd_idx, rd_sel}), 128'(0));
      end
      if (valid) begin
        if (rec == abort_idx) begin
          #2 rst_n = 1'b0;
          #1 chk("async_reset", all_out(), 128'(0));
          aborted = 1'b1; done = 1'b1;
        end else if (rec == stall_idx && stall_cnt < 5) begin
          if (stall_cnt == 0) snap = cur;
          stall_cnt++;
          ready = 1'b0;
        end else begin
          chk($sformatf("rec%0d", rec), cur, exp_rec(rec));
          rec++;
          ready = 1'b1;
        end
      end
      if (m > 1 && !busy) done = 1'b1;
    end
    chk("no_timeout", 128'(done), 128'(1));
    if (aborted) begin
      repeat (3) begin
        @(negedge clk);
        chk("no_clear_in_reset", 128'({buf_clear, frame_done, busy}), 128'(0));
      end
      rst_n = 1'b1;
    end else begin
      chk("records", 128'(rec), 128'(12));
      chk("clear_pulses", 128'(clr_cnt), 128'(1));
      chk("busy_cycles", 128'(busy_cnt), 128'(exp_len));
      chk("clear_edge", 128'(clr_edge), 128'(exp_len));
      chk("sel3_seen", 128'(sel3), 128'(0));
    end
  endtask

  initial begin
    for (int p = 0; p < 4; p++) mem[p][3] = 16'h0000;
    mem[0][0] = 16'h1111; mem[0][1] = 16'h2222; mem[0][2] = 16'h3333;
    mem[1][0] = 16'h4444; mem[1][1] = 16'h5555; mem[1][2] = 16'h6666;
    mem[2][0] = 16'h7777; mem[2][1] = 16'h8888; mem[2][2] = 16'h9999;
    mem[3][0] = 16'hAAAA; mem[3][1] = 16'hBBBB; mem[3][2] = 16'hCCCC;

    rst_n = 1'b0; en = 1'b0; full = 1'b0; ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("reset_outputs", all_out(), 128'(0));
    @(negedge clk) rst_n = 1'b1;

    // EN without a full buffer, then a full buffer without EN
    en = 1'b1; full = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      chk("idle_no_full", 128'({busy, valid}), 128'(0));
    end
    en = 1'b0; full = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      chk("idle_no_en", 128'({busy, valid}), 128'(0));
    end
    full = 1'b0;
    @(negedge clk);

    run_frame(-1, -1, 61, 1'b1);
    // Buffer not refilled: must stay idle even with EN high
    en = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("no_refill_idle", 128'(busy), 128'(0));
    end
    en = 1'b0;
    @(negedge clk);

    run_frame(4, -1, 66, 1'b0);
    @(negedge clk);
    run_frame(-1, 6, 0, 1'b0);
    @(negedge clk);
    run_frame(-1, -1, 61, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
